// File: rtl/guess_game_core.sv
// Two-player sequence-guessing game core: edge-detected key/enter capture, secret entry, scored guesses.
// Define GUESS_HINT_EN to report positional match counts; otherwise match_cnt is tied to zero.
`timescale 1ns/1ps
module guess_game_core #(
  parameter int NUM_KEYS  = 4,
  parameter int MAX_LEN   = 7,
  parameter int MIN_LEN   = 4,
  parameter int MAX_TURNS = 3,
  localparam int SYM_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  localparam int TRN_W = $clog2(MAX_TURNS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                enter,
  output logic [1:0]          phase,
  output logic [LEN_W-1:0]    secret_len,
  output logic [LEN_W-1:0]    guess_len,
  output logic [TRN_W-1:0]    turns_used,
  output logic                result_valid,
  output logic                win,
  output logic                lose,
  output logic                longer,
  output logic                shorter,
  output logic                equal_len,
  output logic [LEN_W-1:0]    match_cnt
);

  typedef enum logic [1:0] {
    PH_SECRET = 2'd0,
    PH_GUESS  = 2'd1,
    PH_DONE   = 2'd2
  } phase_e;

  phase_e                       phase_q, phase_d;
  logic [NUM_KEYS-1:0]          key_q, key_d;
  logic                         enter_q, enter_d;
  logic [LEN_W-1:0]             secret_len_q, secret_len_d;
  logic [LEN_W-1:0]             guess_len_q, guess_len_d;
  logic [LEN_W-1:0]             match_cnt_q, match_cnt_d;
  logic [TRN_W-1:0]             turns_used_q, turns_used_d;
  logic                         result_valid_q, result_valid_d;
  logic                         win_q, win_d;
  logic                         lose_q, lose_d;
  logic                         longer_q, longer_d;
  logic                         shorter_q, shorter_d;
  logic                         equal_len_q, equal_len_d;
  logic [MAX_LEN-1:0][SYM_W-1:0] secret_mem_q, secret_mem_d;
  logic [MAX_LEN-1:0][SYM_W-1:0] guess_mem_q, guess_mem_d;

  logic [NUM_KEYS-1:0] key_rise;
  logic                enter_evt;
  logic                key_evt;
  logic [SYM_W-1:0]    key_sym;
  logic                all_match;
  logic [TRN_W-1:0]    turns_next;
`ifdef GUESS_HINT_EN
  logic [LEN_W-1:0]    hit_cnt;
`endif

  // Enter wins over keys; multi-key presses are treated as noise and dropped.
  always_comb begin
    key_rise  = key & ~key_q;
    enter_evt = enter & ~enter_q;
    key_evt   = !enter_evt && (key_rise != '0) &&
                ((key_rise & (key_rise - NUM_KEYS'(1))) == '0);
    key_sym   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_rise[i]) key_sym = SYM_W'(i);
    end
  end

  // Only positions inside the current guess take part in scoring.
  always_comb begin
    all_match = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < guess_len_q) && (guess_mem_q[i] != secret_mem_q[i])) all_match = 1'b0;
    end
  end

`ifdef GUESS_HINT_EN
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < guess_len_q) && (LEN_W'(i) < secret_len_q) &&
          (guess_mem_q[i] == secret_mem_q[i]))
        hit_cnt = hit_cnt + LEN_W'(1);
    end
  end
`endif

  assign turns_next = turns_used_q + TRN_W'(1);

  always_comb begin
    phase_d        = phase_q;
    key_d          = key;
    enter_d        = enter;
    secret_len_d   = secret_len_q;
    guess_len_d    = guess_len_q;
    match_cnt_d    = match_cnt_q;
    turns_used_d   = turns_used_q;
    result_valid_d = 1'b0;
    win_d          = win_q;
    lose_d         = lose_q;
    longer_d       = longer_q;
    shorter_d      = shorter_q;
    equal_len_d    = equal_len_q;
    secret_mem_d   = secret_mem_q;
    guess_mem_d    = guess_mem_q;

    if (restart) begin
      phase_d      = PH_SECRET;
      secret_len_d = '0;
      guess_len_d  = '0;
      match_cnt_d  = '0;
      turns_used_d = '0;
      win_d        = 1'b0;
      lose_d       = 1'b0;
      longer_d     = 1'b0;
      shorter_d    = 1'b0;
      equal_len_d  = 1'b0;
      secret_mem_d = '0;
      guess_mem_d  = '0;
    end else begin
      unique case (phase_q)
        PH_SECRET: begin
          if (enter_evt) begin
            if (secret_len_q >= LEN_W'(MIN_LEN)) phase_d = PH_GUESS;
          end else if (key_evt && (secret_len_q < LEN_W'(MAX_LEN))) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (LEN_W'(i) == secret_len_q) secret_mem_d[i] = key_sym;
            end
            secret_len_d = secret_len_q + LEN_W'(1);
            // A full secret starts the guessing round without waiting for enter.
            if (secret_len_q == LEN_W'(MAX_LEN - 1)) phase_d = PH_GUESS;
          end
        end
        PH_GUESS: begin
          if (enter_evt) begin
            if (guess_len_q >= LEN_W'(MIN_LEN)) begin
              equal_len_d    = (guess_len_q == secret_len_q);
              longer_d       = (guess_len_q > secret_len_q);
              shorter_d      = (guess_len_q < secret_len_q);
              win_d          = (guess_len_q == secret_len_q) && all_match;
              turns_used_d   = turns_next;
              result_valid_d = 1'b1;
              guess_len_d    = '0;
`ifdef GUESS_HINT_EN
              match_cnt_d    = hit_cnt;
`else
              match_cnt_d    = '0;
`endif
              if ((guess_len_q == secret_len_q) && all_match) begin
                phase_d = PH_DONE;
              end else if (turns_next == TRN_W'(MAX_TURNS)) begin
                lose_d  = 1'b1;
                phase_d = PH_DONE;
              end
            end
          end else if (key_evt && (guess_len_q < LEN_W'(MAX_LEN))) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (LEN_W'(i) == guess_len_q) guess_mem_d[i] = key_sym;
            end
            guess_len_d = guess_len_q + LEN_W'(1);
          end
        end
        default: begin
          phase_d = phase_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q        <= PH_SECRET;
      key_q          <= '0;
      enter_q        <= 1'b0;
      secret_len_q   <= '0;
      guess_len_q    <= '0;
      match_cnt_q    <= '0;
      turns_used_q   <= '0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      longer_q       <= 1'b0;
      shorter_q      <= 1'b0;
      equal_len_q    <= 1'b0;
      secret_mem_q   <= '0;
      guess_mem_q    <= '0;
    end else begin
      phase_q        <= phase_d;
      key_q          <= key_d;
      enter_q        <= enter_d;
      secret_len_q   <= secret_len_d;
      guess_len_q    <= guess_len_d;
      match_cnt_q    <= match_cnt_d;
      turns_used_q   <= turns_used_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      longer_q       <= longer_d;
      shorter_q      <= shorter_d;
      equal_len_q    <= equal_len_d;
      secret_mem_q   <= secret_mem_d;
      guess_mem_q    <= guess_mem_d;
    end
  end

  assign phase        = phase_q;
  assign secret_len   = secret_len_q;
  assign guess_len    = guess_len_q;
  assign turns_used   = turns_used_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign longer       = longer_q;
  assign shorter      = shorter_q;
  assign equal_len    = equal_len_q;
  assign match_cnt    = match_cnt_q;

endmodule

// File: tb/tb_guess_game_core.sv
// Bench for guess_game_core: queue-based game model checked every cycle, plus scripted scenarios.
`timescale 1ns/1ps
module tb_guess_game_core;
  localparam int NK = 4, ML = 7, MN = 4, MT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic [3:0] key = 4'd0;
  logic       enter = 1'b0;
  logic [1:0] phase;
  logic [2:0] secret_len, guess_len, match_cnt;
  logic [1:0] turns_used;
  logic       result_valid, win, lose, longer, shorter, equal_len;

  int total = 0;
  int bad = 0;

  guess_game_core #(.NUM_KEYS(NK), .MAX_LEN(ML), .MIN_LEN(MN), .MAX_TURNS(MT)) dut (
    .clk(clk), .reset(reset), .restart(restart), .key(key), .enter(enter),
    .phase(phase), .secret_len(secret_len), .guess_len(guess_len),
    .turns_used(turns_used), .result_valid(result_valid), .win(win), .lose(lose),
    .longer(longer), .shorter(shorter), .equal_len(equal_len), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  // Game model: sequences as queues, phase as a plain integer.
  int   sq[$];
  int   gq[$];
  int   m_ph = 0, m_turns = 0, m_match = 0;
  bit   m_rv = 0, m_win = 0, m_lose = 0, m_long = 0, m_short = 0, m_eq = 0;
  logic [3:0] m_pk = 4'd0;
  logic       m_pe = 1'b0;
  logic [3:0] rise;
  bit   ent_ev;
  int   sym, hits;

  function automatic void clear_game();
    sq.delete(); gq.delete();
    m_ph = 0; m_turns = 0; m_match = 0;
    m_rv = 0; m_win = 0; m_lose = 0; m_long = 0; m_short = 0; m_eq = 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_game();
      m_pk = 4'd0;
      m_pe = 1'b0;
    end else begin
      rise   = key & ~m_pk;
      ent_ev = enter && !m_pe;
      m_pk   = key;
      m_pe   = enter;
      m_rv   = 0;
      sym    = -1;
      if ($countones(rise) == 1 && !ent_ev)
        for (int i = 0; i < NK; i++) if (rise[i]) sym = i;
      if (restart) begin
        clear_game();
      end else if (m_ph == 0) begin
        if (ent_ev) begin
          if (sq.size() >= MN) m_ph = 1;
        end else if (sym >= 0 && sq.size() < ML) begin
          sq.push_back(sym);
          if (sq.size() == ML) m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (ent_ev) begin
          if (gq.size() >= MN) begin
            m_eq    = (gq.size() == sq.size());
            m_long  = (gq.size() > sq.size());
            m_short = (gq.size() < sq.size());
            hits = 0;
            for (int i = 0; i < gq.size() && i < sq.size(); i++)
              if (gq[i] == sq[i]) hits++;
            m_win = m_eq && (hits == gq.size());
`ifdef GUESS_HINT_EN
            m_match = hits;
`else
            m_match = 0;
`endif
            m_turns++;
            m_rv = 1;
            gq.delete();
            if (m_win) m_ph = 2;
            else if (m_turns == MT) begin m_lose = 1; m_ph = 2; end
          end
        end else if (sym >= 0 && gq.size() < ML) begin
          gq.push_back(sym);
        end
      end
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("phase", int'(phase), m_ph);
    chk("secret_len", int'(secret_len), sq.size());
    chk("guess_len", int'(guess_len), gq.size());
    chk("turns_used", int'(turns_used), m_turns);
    chk("result_valid", int'(result_valid), int'(m_rv));
    chk("win", int'(win), int'(m_win));
    chk("lose", int'(lose), int'(m_lose));
    chk("longer", int'(longer), int'(m_long));
    chk("shorter", int'(shorter), int'(m_short));
    chk("equal_len", int'(equal_len), int'(m_eq));
    chk("match_cnt", int'(match_cnt), m_match);
  end

  // One acting edge with the given levels, then all inputs low; returns just after that edge.
  task automatic cyc(input logic [3:0] k, input bit e, input bit r);
    @(negedge clk);
    key = k; enter = e; restart = r;
    @(negedge clk);
    key = 4'd0; enter = 1'b0; restart = 1'b0;
  endtask

  task automatic press(input int k);
    logic [3:0] v;
    v = 4'd0;
    v[k] = 1'b1;
    cyc(v, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_slen"}, int'(secret_len), 0);
    chk({tag, "_glen"}, int'(guess_len), 0);
    chk({tag, "_turns"}, int'(turns_used), 0);
    chk({tag, "_flags"}, int'({result_valid, win, lose, longer, shorter, equal_len}), 0);
    chk({tag, "_match"}, int'(match_cnt), 0);
  endtask

  int exp_m;
  int r;

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Perfect guess wins on the first turn.
    for (int i = 0; i < 4; i++) press(i);
    cyc(4'd0, 1'b1, 1'b0);
    chk("s1_phase_guess", int'(phase), 1);
    for (int i = 0; i < 4; i++) press(i);
    cyc(4'd0, 1'b1, 1'b0);
`ifdef GUESS_HINT_EN
    exp_m = 4;
`else
    exp_m = 0;
`endif
    chk("s1_rv", int'(result_valid), 1);
    chk("s1_win", int'(win), 1);
    chk("s1_eq", int'(equal_len), 1);
    chk("s1_turns", int'(turns_used), 1);
    chk("s1_phase", int'(phase), 2);
    chk("s1_match", int'(match_cnt), exp_m);
    @(negedge clk);
    chk("s1_rv_pulse", int'(result_valid), 0);
    cyc(4'd0, 1'b0, 1'b1);
    chk("restart_phase", int'(phase), 0);
    chk("restart_win", int'(win), 0);

    // Three reversed guesses lose.
    for (int i = 0; i < 4; i++) press(i);
    cyc(4'd0, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) begin
      for (int i = 3; i >= 0; i--) press(i);
      cyc(4'd0, 1'b1, 1'b0);
    end
    chk("s2_lose", int'(lose), 1);
    chk("s2_turns", int'(turns_used), 3);
    chk("s2_phase", int'(phase), 2);
    chk("s2_match", int'(match_cnt), 0);
    press(1); press(2);
    chk("s2_glen_done", int'(guess_len), 0);
    cyc(4'd0, 1'b0, 1'b1);

    // Full-length secret auto-advances; short guess is scored as shorter.
    for (int i = 0; i < 7; i++) press(i % 4);
    chk("s3_auto_phase", int'(phase), 1);
    for (int i = 0; i < 4; i++) press(0);
    cyc(4'd0, 1'b1, 1'b0);
    chk("s3_shorter", int'(shorter), 1);
    chk("s3_longer", int'(longer), 0);
    chk("s3_win", int'(win), 0);
    chk("s3_turns", int'(turns_used), 1);
    cyc(4'd0, 1'b0, 1'b1);

    // Rejected enter, multi-key press, key with enter.
    press(0); press(1); press(2);
    cyc(4'd0, 1'b1, 1'b0);
    chk("s4_early_enter", int'(phase), 0);
    cyc(4'b0011, 1'b0, 1'b0);
    chk("s4_two_keys", int'(secret_len), 3);
    cyc(4'b1000, 1'b1, 1'b0);
    chk("s4_key_enter", int'(secret_len), 3);
    press(3);
    chk("s4_after", int'(secret_len), 4);

    // Async reset pulse mid-guess.
    cyc(4'd0, 1'b1, 1'b0);
    press(1); press(2);
    chk("s5_glen", int'(guess_len), 2);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("async_rst");
    reset = 1'b0;

    // Randomised play, checked each cycle by the model compare.
    repeat (3000) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 40) key = 4'b0001 << $urandom_range(0, 3);
      else if (r < 48) key = 4'($urandom_range(0, 15));
      else key = 4'd0;
      enter   = ($urandom_range(0, 9) == 0);
      restart = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    key = 4'd0; enter = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
